// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack memory hierarchy.
package hack_pkg;

  localparam int unsigned WORD_WIDTH  = 16;
  localparam int unsigned RAM8_ADDR_W = 3;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_16bit_bit_cell.sv
// One-bit storage cell: hold/load mux feeding a D flop with synchronous clear.
module bit_cell (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic load,
  output logic out
);

  logic d_c;

  always_comb begin
    d_c = out;
    if (load) d_c = in;
  end

  always_ff @(posedge clk) begin
    if (reset) out <= 1'b0;
    else       out <= d_c;
  end

endmodule

// File: rtl/reg_16bit.sv
// Word register: WIDTH independent bit cells sharing clock, reset and load.
module reg_16bit
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    bit_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .in    (in[k]),
      .load  (load),
      .out   (out[k])
    );
  end

endmodule

// File: tb/tb_reg_16bit.sv
// Directed self-checking bench for reg_16bit.
module tb_reg_16bit;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;

  int checks;
  int errors;

  reg_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; in = 16'hFFFF;
    step();
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset: out=%h expected=%h", out, 16'h0000);
    end
    reset = 1'b0; load = 1'b0; in = 16'h0000;
    step();
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: out=%h expected=%h", out, 16'h0000);
    end
  endtask

  task automatic test_load();
    load = 1'b1; in = 16'hA5C3;
    #2;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL read_during_write: out=%h expected=%h", out, 16'h0000);
    end
    step();
    checks++;
    if (out !== 16'hA5C3) begin
      errors++;
      $display("FAIL load: out=%h expected=%h", out, 16'hA5C3);
    end
    load = 1'b0; in = 16'h0F0F;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out !== 16'hA5C3) begin
        errors++;
        $display("FAIL load_stable[%0d]: out=%h expected=%h", i, out, 16'hA5C3);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] pats [4];
    pats[0] = 16'h0000; pats[1] = 16'hFFFF; pats[2] = 16'h5555; pats[3] = 16'h0000;
    load = 1'b1; in = 16'h1234;
    step();
    checks++;
    if (out !== 16'h1234) begin
      errors++;
      $display("FAIL hold_setup: out=%h expected=%h", out, 16'h1234);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in = pats[i];
      step();
      checks++;
      if (out !== 16'h1234) begin
        errors++;
        $display("FAIL hold[%0d]: out=%h expected=%h", i, out, 16'h1234);
      end
    end
  endtask

  task automatic test_glitch();
    // Pulse load and wiggle in between edges; the edge itself sees load=0.
    load = 1'b0;
    #1 load = 1'b1; in = 16'hDEAD;
    #1 load = 1'b0; in = 16'h0000;
    #1 in = 16'hFFFF;
    step();
    checks++;
    if (out !== 16'h1234) begin
      errors++;
      $display("FAIL glitch: out=%h expected=%h", out, 16'h1234);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    vals[0] = 16'h0001; vals[1] = 16'h8000; vals[2] = 16'h7FFE;
    load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = vals[i];
      step();
      checks++;
      if (out !== vals[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: out=%h expected=%h", i, out, vals[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; in = 16'hBEEF;
    step();
    checks++;
    if (out !== 16'hBEEF) begin
      errors++;
      $display("FAIL priority_setup: out=%h expected=%h", out, 16'hBEEF);
    end
    reset = 1'b1; load = 1'b1; in = 16'h1111;
    step();
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL priority_reset: out=%h expected=%h", out, 16'h0000);
    end
    reset = 1'b0; load = 1'b1; in = 16'h2222;
    step();
    checks++;
    if (out !== 16'h2222) begin
      errors++;
      $display("FAIL priority_release: out=%h expected=%h", out, 16'h2222);
    end
    load = 1'b0;
  endtask

  task automatic test_walking_one();
    logic [15:0] pat;
    load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pat = 16'h0001 << i;
      in = pat;
      step();
      checks++;
      if (out !== pat) begin
        errors++;
        $display("FAIL walking_one[%0d]: out=%h expected=%h", i, out, pat);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; load = 1'b0; in = 16'h0000;
    #2;
    test_reset();
    test_load();
    test_hold();
    test_glitch();
    test_back_to_back();
    test_priority();
    test_walking_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
